// File: rtl/cr_segmented_accumulator_pkg.sv
// Shared types and helpers for the segmented (SIMD-lane) PRNG accumulator.
// Also provides a default for LEN_MAX_CR, which sets the run-length counter width.
`ifndef LEN_MAX_CR
`define LEN_MAX_CR 32
`endif

package cr_segmented_accumulator_pkg;

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_RES = 2'd1,
        S_OUT = 2'd2
    } cr_state_t;

    // 32-bit word plus its carry-out, as produced by the stage-1 adders
    typedef struct packed {
        logic        c;
        logic [31:0] v;
    } u32_w_c_t;

    // Bit i is set when word i starts a lane of 32 << lane_log bits.
    // lane_log values above log_n clamp to one lane spanning all words.
    function automatic logic [31:0] make_lane_start(input int unsigned lane_log,
                                                    input int unsigned log_n);
        int unsigned eff;
        logic [31:0] m;
        eff = (lane_log > log_n) ? log_n : lane_log;
        for (int unsigned i = 0; i < 32; i++)
            m[i] = ((i & ((32'd1 << eff) - 32'd1)) == 32'd0);
        return m;
    endfunction

endpackage

// File: rtl/cr_segmented_accumulator_seg_carry_resolve.sv
// Combinational lane-aware carry resolution over stage-1 partial sums.
// Carries ripple low to high and restart at every lane start with carry-in = sub.
module cr_segmented_accumulator_seg_carry_resolve
    import cr_segmented_accumulator_pkg::*;
#(
    parameter int N_WORDS = 8
) (
    input  u32_w_c_t [N_WORDS-1:0] i_ps,
    input  logic [N_WORDS-1:0]     i_lane_start,
    input  logic                   i_sub,
    output logic [N_WORDS*32-1:0]  o_words,
    output logic [N_WORDS-1:0]     o_lane_cout
);

    logic [N_WORDS-1:0] w_top;

    // A word is the top of its lane when the next word starts a new lane
    assign w_top = {1'b1, i_lane_start[N_WORDS-1:1]};

    // Ripple carries across words, containing them at lane boundaries
    always_comb begin
        logic        carry;
        logic        cin;
        logic        cout;
        logic [32:0] sum;
        carry       = 1'b0;
        o_words     = '0;
        o_lane_cout = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            cin  = i_lane_start[i] ? i_sub : carry;
            sum  = {1'b0, i_ps[i].v} + {32'd0, cin};
            cout = i_ps[i].c | sum[32];
            o_words[i*32 +: 32] = sum[31:0];
            o_lane_cout[i]      = cout & w_top[i];
            carry = cout;
        end
    end

endmodule

// File: rtl/cr_segmented_accumulator.sv
// Segmented accumulator: folds len PRNG words into a wide register split into
// lanes of 32 << lane_log bits (add or subtract), then presents the result.
// Optional macro CR_LANE_OVF_EN adds the sticky per-lane overflow output ovf_o.
module cr_segmented_accumulator
    import cr_segmented_accumulator_pkg::*;
#(
    parameter int N_WORDS = 8,
    parameter int LOG_W   = $clog2(N_WORDS) + 1,
    parameter int CNT_W   = `LEN_MAX_CR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic [LOG_W-1:0]      lane_log_i,
    input  logic                  sub_i,
    input  logic [CNT_W-1:0]      len_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [N_WORDS*32-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [N_WORDS*32-1:0] acc_o,
`ifdef CR_LANE_OVF_EN
    output logic [N_WORDS-1:0]    ovf_o,
`endif
    output logic [CNT_W-1:0]      cnt_o
);

    localparam int unsigned LOG2N = $clog2(N_WORDS);

    cr_state_t r_state, w_state_nxt;

    logic [N_WORDS*32-1:0]  r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic [LOG_W-1:0]       r_lane_log;
    logic                   r_sub;
    logic [CNT_W-1:0]       r_len;
    u32_w_c_t [N_WORDS-1:0] r_ps;
    u32_w_c_t [N_WORDS-1:0] w_ps;

    logic                   w_hs;
    logic                   w_sub;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_len_eff;
    logic [31:0]            w_start_all;
    logic [N_WORDS-1:0]     w_lane_start;
    logic [N_WORDS*32-1:0]  w_resolved;
    logic [N_WORDS-1:0]     w_lane_cout;

    // A handshake coinciding with clear_i is discarded
    assign w_hs      = in_valid_i && in_ready_o && !clear_i;
    // The first word of a run uses the config being latched alongside it
    assign w_sub     = (r_cnt == '0) ? sub_i : r_sub;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_len_eff = (r_len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : r_len;

    assign w_start_all  = make_lane_start(32'(r_lane_log), LOG2N);
    assign w_lane_start = w_start_all[N_WORDS-1:0];

    generate
        if (N_WORDS < 32) begin : g_start_unused
            logic w_start_unused;
            assign w_start_unused = ^w_start_all[31:N_WORDS];
        end
    endgenerate

    // Stage 1: per-word sum of acc and (optionally inverted) data, carry kept aside
    always_comb begin
        w_ps = '0;
        for (int i = 0; i < N_WORDS; i++)
            {w_ps[i].c, w_ps[i].v} = {1'b0, r_acc[i*32 +: 32]}
                + {1'b0, (w_sub ? ~in_data_i[i*32 +: 32] : in_data_i[i*32 +: 32])};
    end

    cr_segmented_accumulator_seg_carry_resolve #(
        .N_WORDS (N_WORDS)
    ) u_resolve (
        .i_ps         (r_ps),
        .i_lane_start (w_lane_start),
        .i_sub        (r_sub),
        .o_words      (w_resolved),
        .o_lane_cout  (w_lane_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_ACC;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = S_ACC;
        end else begin
            case (r_state)
                S_ACC:   if (w_hs) w_state_nxt = S_RES;
                S_RES:   w_state_nxt = (w_cnt_nxt == w_len_eff) ? S_OUT : S_ACC;
                S_OUT:   if (out_ready_i) w_state_nxt = S_ACC;
                default: w_state_nxt = S_ACC;
            endcase
        end
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready_o  = (r_state == S_ACC);
        out_valid_o = (r_state == S_OUT);
    end

    // Datapath: partial sums, accumulator, run count and latched config
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ps       <= '0;
            r_lane_log <= '0;
            r_sub      <= 1'b0;
            r_len      <= '0;
        end else if (clear_i) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_ACC: if (w_hs) begin
                    r_ps <= w_ps;
                    if (r_cnt == '0) begin
                        r_lane_log <= lane_log_i;
                        r_sub      <= sub_i;
                        r_len      <= len_i;
                    end
                end
                S_RES: begin
                    r_acc <= w_resolved;
                    r_cnt <= w_cnt_nxt;
                end
                S_OUT: if (out_ready_i) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign acc_o = r_acc;
    assign cnt_o = r_cnt;

`ifdef CR_LANE_OVF_EN
    logic [N_WORDS-1:0] r_ovf;

    // Sticky lane overflow: discarded carry when adding, missing carry when subtracting
    always_ff @(posedge clk) begin
        if (rst || clear_i)
            r_ovf <= '0;
        else if (r_state == S_RES)
            r_ovf <= r_ovf | (r_sub ? (~w_lane_cout & {1'b1, w_lane_start[N_WORDS-1:1]})
                                    : w_lane_cout);
        else if (r_state == S_OUT && out_ready_i)
            r_ovf <= '0;
    end

    assign ovf_o = r_ovf;
`else
    logic w_cout_unused;
    assign w_cout_unused = ^w_lane_cout;
`endif

endmodule

// File: tb/tb_cr_segmented_accumulator.sv
`timescale 1ns/1ps
module tb_cr_segmented_accumulator;

    localparam int N_WORDS = 8;
    localparam int LOG_W   = 4;
    localparam int CNT_W   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear_i;
    logic [LOG_W-1:0]   lane_log_i;
    logic               sub_i;
    logic [CNT_W-1:0]   len_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [255:0]       in_data_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [255:0]       acc_o;
    logic [CNT_W-1:0]   cnt_o;
`ifdef CR_LANE_OVF_EN
    logic [7:0]         ovf_o;
`endif

    int checks = 0;
    int errors = 0;

    cr_segmented_accumulator #(.N_WORDS(N_WORDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear_i),
        .lane_log_i  (lane_log_i),
        .sub_i       (sub_i),
        .len_i       (len_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .acc_o       (acc_o),
`ifdef CR_LANE_OVF_EN
        .ovf_o       (ovf_o),
`endif
        .cnt_o       (cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Present one word from a negedge; returns two negedges later (acc updated)
    task automatic send(input logic [255:0] d);
        in_valid_i = 1'b1;
        in_data_i  = d;
        @(negedge clk);
        in_valid_i = 1'b0;
        in_data_i  = '0;
        @(negedge clk);
    endtask

    task automatic drain();
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (acc_o !== '0) begin errors++; $display("FAIL reset_acc got %h want 0", acc_o); end
        checks++; if (cnt_o !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
    endtask

    task automatic test_lane_boundary();
        lane_log_i = 4'd0; sub_i = 1'b0; len_i = 32'd2;
        send({8{32'hFFFF_FFFF}});
        checks++; if (cnt_o !== 32'd1) begin errors++; $display("FAIL lb_cnt1 got %0d want 1", cnt_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL lb_valid1 got %b want 0", out_valid_o); end
        // mid-run config change must be ignored
        lane_log_i = 4'd3; len_i = 32'd5; sub_i = 1'b1;
        send({8{32'hFFFF_FFFF}});
        checks++; if (acc_o !== {8{32'hFFFF_FFFE}}) begin errors++; $display("FAIL lb_acc got %h want %h", acc_o, {8{32'hFFFF_FFFE}}); end
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL lb_valid2 got %b want 1", out_valid_o); end
        checks++; if (cnt_o !== 32'd2) begin errors++; $display("FAIL lb_cnt2 got %0d want 2", cnt_o); end
`ifdef CR_LANE_OVF_EN
        checks++; if (ovf_o !== 8'hFF) begin errors++; $display("FAIL lb_ovf got %h want ff", ovf_o); end
`endif
        drain();
    endtask

    task automatic test_full_chain();
        lane_log_i = 4'd3; sub_i = 1'b0; len_i = 32'd2;
        send({8{32'hFFFF_FFFF}});
        checks++; if (acc_o !== {8{32'hFFFF_FFFF}}) begin errors++; $display("FAIL fc_acc1 got %h want all ones", acc_o); end
        send(256'd1);
        checks++; if (acc_o !== '0) begin errors++; $display("FAIL fc_acc2 got %h want 0", acc_o); end
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL fc_valid got %b want 1", out_valid_o); end
`ifdef CR_LANE_OVF_EN
        checks++; if (ovf_o !== 8'h80) begin errors++; $display("FAIL fc_ovf got %h want 80", ovf_o); end
`endif
        drain();
    endtask

    task automatic test_sub64();
        logic [255:0] d;
        d = '0;
        d[0*32 +: 32] = 32'd1; d[2*32 +: 32] = 32'd1;
        d[4*32 +: 32] = 32'd1; d[6*32 +: 32] = 32'd1;
        lane_log_i = 4'd1; sub_i = 1'b1; len_i = 32'd1;
        send(d);
        checks++; if (acc_o !== {8{32'hFFFF_FFFF}}) begin errors++; $display("FAIL sub64_acc got %h want all ones", acc_o); end
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL sub64_valid got %b want 1", out_valid_o); end
`ifdef CR_LANE_OVF_EN
        checks++; if (ovf_o !== 8'hAA) begin errors++; $display("FAIL sub64_ovf got %h want aa", ovf_o); end
`endif
        drain();
    endtask

    task automatic test_clamp_latency();
        lane_log_i = 4'd7; sub_i = 1'b0; len_i = 32'd2;
        in_valid_i = 1'b1; in_data_i = 256'hFFFF_FFFF;
        @(negedge clk);
        in_valid_i = 1'b0; in_data_i = '0;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL lat_ready_res got %b want 0", in_ready_o); end
        checks++; if (acc_o !== '0) begin errors++; $display("FAIL lat_acc_early got %h want 0", acc_o); end
        @(negedge clk);
        checks++; if (acc_o !== 256'hFFFF_FFFF) begin errors++; $display("FAIL lat_acc got %h want ffffffff", acc_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL lat_ready_acc got %b want 1", in_ready_o); end
        send(256'd1);
        checks++; if (acc_o !== 256'h1_0000_0000) begin errors++; $display("FAIL clamp_acc got %h want 100000000", acc_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL clamp_ready_out got %b want 0", in_ready_o); end
    endtask

    // Continues from the S_OUT state left by test_clamp_latency
    task automatic test_backpressure();
        int bad;
        bad = 0;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = {8{32'h1234_5678}};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (acc_o !== 256'h1_0000_0000 || out_valid_o !== 1'b1 || in_ready_o !== 1'b0) bad++;
        end
        in_valid_i = 1'b0; in_data_i = '0;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad); end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_valid got %b want 0", out_valid_o); end
        checks++; if (cnt_o !== '0) begin errors++; $display("FAIL bp_cnt got %0d want 0", cnt_o); end
        checks++; if (acc_o !== '0) begin errors++; $display("FAIL bp_acc got %h want 0", acc_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready got %b want 1", in_ready_o); end
    endtask

    task automatic test_abort();
        lane_log_i = 4'd0; sub_i = 1'b0; len_i = 32'd3;
        send({8{32'h0000_0001}});
        checks++; if (cnt_o !== 32'd1) begin errors++; $display("FAIL ab_cnt1 got %0d want 1", cnt_o); end
        // second word accepted, clear lands while it is in S_RES
        in_valid_i = 1'b1; in_data_i = {8{32'h0000_0001}};
        @(negedge clk);
        in_valid_i = 1'b0;
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        checks++; if (acc_o !== '0) begin errors++; $display("FAIL ab_acc got %h want 0", acc_o); end
        checks++; if (cnt_o !== '0) begin errors++; $display("FAIL ab_cnt got %0d want 0", cnt_o); end
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL ab_state got ready=%b valid=%b want 1/0", in_ready_o, out_valid_o); end
        // handshake coinciding with clear is ignored
        in_valid_i = 1'b1; clear_i = 1'b1; in_data_i = {8{32'hAAAA_AAAA}};
        @(negedge clk);
        in_valid_i = 1'b0; clear_i = 1'b0; in_data_i = '0;
        @(negedge clk);
        checks++; if (acc_o !== '0 || cnt_o !== '0) begin errors++; $display("FAIL ab_hs_clear got acc=%h cnt=%0d want 0/0", acc_o, cnt_o); end
        // new run latches a fresh config
        lane_log_i = 4'd3; sub_i = 1'b0; len_i = 32'd2;
        send(256'hFFFF_FFFF);
        lane_log_i = 4'd0;
        send(256'd1);
        checks++; if (acc_o !== 256'h1_0000_0000) begin errors++; $display("FAIL ab_new_acc got %h want 100000000", acc_o); end
        checks++; if (out_valid_o !== 1'b1 || cnt_o !== 32'd2) begin errors++; $display("FAIL ab_new_done got valid=%b cnt=%0d want 1/2", out_valid_o, cnt_o); end
        drain();
    endtask

    initial begin
        rst = 1'b1; clear_i = 1'b0; lane_log_i = '0; sub_i = 1'b0; len_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_lane_boundary();
        test_full_chain();
        test_sub64();
        test_clamp_latency();
        test_backpressure();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cr_segmented_accumulator.md
Name: cr_segmented_accumulator

Overview:
- Accumulates a stream of PRNG words into one wide register that is split into SIMD lanes.
- Lane width is run-time selectable: 32 << lane_log_i bits.
- Supports add or subtract per run; carries are contained at lane boundaries.
- After a programmed number of words, presents the result on a valid/ready output, then restarts.
- Parametrised successor of the fixed 256-bit, 3-mode carry-mask scheme; feeds correlated-randomness (CR) share generation downstream of the PRNG.

Parameters:
- N_WORDS, 8, number of 32-bit words in the accumulator (power of 2, 2..32).
- LOG_W, $clog2(N_WORDS)+1, width of lane_log_i.
- CNT_W, `LEN_MAX_CR (32), width of the run-length count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clear_i  in  1  synchronous abort; returns the block to its empty state.
- lane_log_i  in  LOG_W  lane width = 32 << lane_log_i; values above $clog2(N_WORDS) clamp to full width.
- sub_i  in  1  0 = acc += data, 1 = acc -= data.
- len_i  in  CNT_W  words per run; 0 is treated as 1.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  block can accept a word.
- in_data_i  in  N_WORDS*32  PRNG word.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- acc_o  out  N_WORDS*32  accumulated result.
- cnt_o  out  CNT_W  words folded into the current run.

Behaviour:
- Reset (rst=1):
  - State goes to S_ACC.
  - acc_o=0, cnt_o=0, out_valid_o=0.
  - in_ready_o=1 from the first cycle after reset.
- Config latch:
  - lane_log_i, sub_i and len_i are captured on the handshake where cnt_o==0.
  - They are held for the whole run; mid-run changes are ignored.
- S_ACC:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o, stage 1 registers per-word partial sums {carry, val} = acc_w + (sub ? ~data_w : data_w).
  - Move to S_RES.
- S_RES:
  - in_ready_o=0.
  - Resolve carries across words by ripple, low word to high word.
  - Word i is a lane start iff i mod 2^lane_log == 0.
  - At a lane start, carry-in = sub. Otherwise carry-in = the resolved carry-out of word i-1.
  - Carry-out of a lane's top word is discarded (modular per lane).
  - acc is written, and cnt increments.
  - If the new cnt == effective len, go to S_OUT. Otherwise go to S_ACC.
- Timing:
  - Throughput is 1 word per 2 cycles.
  - A word accepted at cycle t is visible on acc_o at t+2.
- S_OUT:
  - out_valid_o=1 and acc_o is stable.
  - in_ready_o=0.
  - On out_ready_i: acc=0, cnt=0, go to S_ACC.
  - out_valid_o never drops without the handshake, except on rst or clear_i.
- clear_i:
  - Priority is below rst and above everything else.
  - Any state goes to S_ACC with acc=0 and cnt=0; an in-flight word is dropped.
  - An input handshake in the same cycle is ignored.
- cnt_o equals the number of words already resolved into acc.
- Subtraction semantics per lane: acc + ~d + 1. Borrow does not cross lanes.

Optional Feature:
- Macro: CR_LANE_OVF_EN.
- Defined:
  - Adds output ovf_o [N_WORDS] (in, wrt the consumer: out).
  - Bit i is a sticky flag set when the lane whose top word is i produces a discarded carry-out (add) or a missing carry (sub, i.e. borrow).
  - Bits for non-top words stay 0.
  - Cleared with acc: reset, clear_i, and the output handshake.
  - Valid alongside acc_o in S_OUT.
- Undefined: the port is absent and no flag logic is built.

Decomposition:
- Package additions to the shared package:
  - cr_state_t enum {S_ACC, S_RES, S_OUT}.
  - Parametrised lane-start mask function make_lane_start(lane_log), generalising make_carry_mask.
  - u32_w_c_t is reused for the stage-1 partial sums.
- Sub-module seg_carry_resolve:
  - Purely combinational.
  - Inputs: partial sums, lane-start mask, sub.
  - Outputs: resolved words and per-lane carry-outs.

Test Plan:
- Carry stops at lane boundaries: N_WORDS=8, lane_log=0, len=2, add 0xFFFFFFFF in all words twice. Expect acc words all 0xFFFFFFFE and out_valid after the second word.
- Full-width carry chain: lane_log=3, acc=0 plus 2^256-1, then plus 1. Expect acc=0; with CR_LANE_OVF_EN, ovf_o[7]=1 and the other bits 0.
- 64-bit lanes in subtract mode: lane_log=1, sub=1, len=1, data=1 in words 0, 2, 4, 6. Expect each 64-bit lane = 0xFFFFFFFF_FFFFFFFF.
- Clamp and latency: lane_log=7 (clamps to 256-bit). Expect acc_o to update exactly 2 cycles after acceptance, and in_ready_o low in S_RES and S_OUT.
- Backpressure: hold out_ready_i=0 for 10 cycles. Expect acc_o and out_valid_o stable; after the handshake, cnt_o=0, acc_o=0, and in_ready_o=1 the next cycle.
- Abort mid-run: assert clear_i in S_RES with len=3, cnt=1. Expect acc=0, cnt=0, state S_ACC; the next run latches the new config.
